// File: rtl/square_wave_period_meter_if.sv
// Sample-domain bus of the square-wave period meter: strobe and sample in,
// measured period/high time with their valid and stall flags out.
interface square_wave_period_meter_if #(
    parameter int COUNT_WIDTH = 24
);
    logic                   audio_clk_en;
    logic signed [15:0]     in;
    logic [COUNT_WIDTH-1:0] period;
    logic [COUNT_WIDTH-1:0] high_time;
    logic                   valid;
    logic                   stalled;

    modport master (
        output audio_clk_en,
        output in,
        input  period,
        input  high_time,
        input  valid,
        input  stalled
    );

    modport slave (
        input  audio_clk_en,
        input  in,
        output period,
        output high_time,
        output valid,
        output stalled
    );
endinterface

// File: rtl/square_wave_period_meter.sv
// Measures rising-to-rising period and high time (in audio samples) of a
// signed 16-bit square-ish waveform, using a hysteresis level detector.
module square_wave_period_meter #(
    parameter int THRESH_HIGH     = 12288,
    parameter int THRESH_LOW      = 4096,
    parameter int COUNT_WIDTH     = 24,
    parameter int TIMEOUT_SAMPLES = 48000
) (
    input  logic                       clk,
    input  logic                       I_RST,
    square_wave_period_meter_if.slave  bus
);

    typedef enum logic [1:0] {
        SYNC      = 2'd0,
        ARMED     = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } state_t;

    localparam logic signed [15:0]     TH_HI     = 16'(THRESH_HIGH);
    localparam logic signed [15:0]     TH_LO     = 16'(THRESH_LOW);
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_C = COUNT_WIDTH'(TIMEOUT_SAMPLES);
    localparam logic [COUNT_WIDTH-1:0] ONE_C     = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] ZERO_C    = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] ONES_C    = {COUNT_WIDTH{1'b1}};

    // Period sum is formed one bit wider and clamped so a huge period never wraps.
    function automatic logic [COUNT_WIDTH-1:0] sat_sum(
        input logic [COUNT_WIDTH-1:0] a,
        input logic [COUNT_WIDTH-1:0] b
    );
        logic [COUNT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[COUNT_WIDTH]) begin
            sat_sum = ONES_C;
        end else begin
            sat_sum = s[COUNT_WIDTH-1:0];
        end
    endfunction

    state_t                 state_r, state_s;
    logic                   level_r, level_s, next_level_s;
    logic [COUNT_WIDTH-1:0] hi_cnt_r, hi_cnt_s;
    logic [COUNT_WIDTH-1:0] lo_cnt_r, lo_cnt_s;
    logic [COUNT_WIDTH-1:0] idle_cnt_r, idle_cnt_s;
    logic [COUNT_WIDTH-1:0] period_r, period_s;
    logic [COUNT_WIDTH-1:0] high_time_r, high_time_s;
    logic                   valid_r, valid_s;
    logic                   stalled_r, stalled_s;
    logic                   rise_s, fall_s;
    logic [COUNT_WIDTH-1:0] hi_inc_s, lo_inc_s, idle_inc_s;

    // Hysteresis detector: inputs between the thresholds keep the previous level.
    always_comb begin
        next_level_s = level_r;
        if (bus.in >= TH_HI) begin
            next_level_s = 1'b1;
        end else if (bus.in <= TH_LO) begin
            next_level_s = 1'b0;
        end else begin
            next_level_s = level_r;
        end
    end

    assign rise_s     = bus.audio_clk_en & next_level_s & ~level_r;
    assign fall_s     = bus.audio_clk_en & ~next_level_s & level_r;
    assign hi_inc_s   = hi_cnt_r + ONE_C;
    assign lo_inc_s   = lo_cnt_r + ONE_C;
    assign idle_inc_s = idle_cnt_r + ONE_C;

    // Next-state and datapath; a detected edge sample opens the new phase,
    // and a rise beats a timeout landing on the same sample.
    always_comb begin
        state_s     = state_r;
        level_s     = level_r;
        hi_cnt_s    = hi_cnt_r;
        lo_cnt_s    = lo_cnt_r;
        idle_cnt_s  = idle_cnt_r;
        period_s    = period_r;
        high_time_s = high_time_r;
        stalled_s   = stalled_r;
        valid_s     = 1'b0;
        if (bus.audio_clk_en) begin
            level_s = next_level_s;
            case (state_r)
                SYNC: begin
                    if (!next_level_s) begin
                        state_s    = ARMED;
                        idle_cnt_s = ZERO_C;
                    end else begin
                        state_s = SYNC;
                    end
                end
                ARMED: begin
                    if (rise_s) begin
                        hi_cnt_s   = ONE_C;
                        lo_cnt_s   = ZERO_C;
                        idle_cnt_s = ZERO_C;
                        state_s    = MEAS_HIGH;
                    end else if (idle_inc_s >= TIMEOUT_C) begin
                        stalled_s  = 1'b1;
                        idle_cnt_s = ZERO_C;
                    end else begin
                        idle_cnt_s = idle_inc_s;
                    end
                end
                MEAS_HIGH: begin
                    if (fall_s) begin
                        lo_cnt_s = ONE_C;
                        state_s  = MEAS_LOW;
                    end else if (hi_inc_s >= TIMEOUT_C) begin
                        stalled_s = 1'b1;
                        hi_cnt_s  = ZERO_C;
                        lo_cnt_s  = ZERO_C;
                        state_s   = SYNC;
                    end else begin
                        hi_cnt_s = hi_inc_s;
                    end
                end
                MEAS_LOW: begin
                    if (rise_s) begin
                        period_s    = sat_sum(hi_cnt_r, lo_cnt_r);
                        high_time_s = hi_cnt_r;
                        valid_s     = 1'b1;
                        stalled_s   = 1'b0;
                        hi_cnt_s    = ONE_C;
                        lo_cnt_s    = ZERO_C;
                        state_s     = MEAS_HIGH;
                    end else if (lo_inc_s >= TIMEOUT_C) begin
                        stalled_s  = 1'b1;
                        hi_cnt_s   = ZERO_C;
                        lo_cnt_s   = ZERO_C;
                        idle_cnt_s = ZERO_C;
                        state_s    = ARMED;
                    end else begin
                        lo_cnt_s = lo_inc_s;
                    end
                end
                default: begin
                    state_s    = SYNC;
                    hi_cnt_s   = ZERO_C;
                    lo_cnt_s   = ZERO_C;
                    idle_cnt_s = ZERO_C;
                end
            endcase
        end else begin
            valid_s = 1'b0;
        end
    end

    // State and result registers; async reset drops any partial measurement.
    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            state_r     <= SYNC;
            level_r     <= 1'b0;
            hi_cnt_r    <= ZERO_C;
            lo_cnt_r    <= ZERO_C;
            idle_cnt_r  <= ZERO_C;
            period_r    <= ZERO_C;
            high_time_r <= ZERO_C;
            valid_r     <= 1'b0;
            stalled_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            level_r     <= level_s;
            hi_cnt_r    <= hi_cnt_s;
            lo_cnt_r    <= lo_cnt_s;
            idle_cnt_r  <= idle_cnt_s;
            period_r    <= period_s;
            high_time_r <= high_time_s;
            valid_r     <= valid_s;
            stalled_r   <= stalled_s;
        end
    end

    assign bus.period    = period_r;
    assign bus.high_time = high_time_r;
    assign bus.valid     = valid_r;
    assign bus.stalled   = stalled_r;

endmodule
